mem_bus_arbiter: RTL and testbench

Shares one single-beat memory port between the instruction-fetch request port (driven by the fetch unit) and the data-access request port (driven by the load/store unit). It sits between the core and the memory/cache interface. It accepts at most one transaction at a time, registers the granted request, drives it to memory, and returns the response to the owning requester as a one-cycle `data_ok` pulse. Tie-breaking between simultaneous requesters is selectable at compile time.

---
 rtl/mem_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-beat memory port between the fetch unit
// (ireq_*/iresp_*) and the load/store unit (dreq_*/dresp_*).
// One transaction in flight at a time: IDLE grants, BUSY holds the registered
// request on mreq_* until mresp_ready, DONE pulses the owner's data_ok.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   ireq_*/iresp_*      fetch request (64b addr) / 32b instruction response
//   dreq_*/dresp_*      data request (addr, size, strobe, wdata) / 64b response
//   mreq_*/mresp_*      memory request fields / completion + read data
// Build option: define ARB_RR_EN for round-robin tie-break; otherwise a tie
// always grants the data port.
module mem_bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        mreq_valid,
  output logic        mreq_write,
  output logic [63:0] mreq_addr,
  output logic [2:0]  mreq_size,
  output logic [7:0]  mreq_strobe,
  output logic [63:0] mreq_wdata,
  input  logic        mresp_ready,
  input  logic [63:0] mresp_rdata
);

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = 3;
  localparam int unsigned BW = 8;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [SW-1:0]   size_q, size_d;
  logic [BW-1:0]   strobe_q, strobe_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            write_q, write_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            tie_to_d;
  logic            grant_is_d;

  // Who wins when both requesters are valid in IDLE
`ifdef ARB_RR_EN
  assign tie_to_d = (owner_q == OWN_I);
`else
  assign tie_to_d = 1'b1;
`endif

  // Next-state and request-register update
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    size_d     = size_q;
    strobe_d   = strobe_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    rdata_d    = rdata_q;
    grant_is_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ireq_valid || dreq_valid) begin
          grant_is_d = dreq_valid && (!ireq_valid || tie_to_d);
          state_d    = BUSY;
          if (grant_is_d) begin
            owner_d  = OWN_D;
            addr_d   = dreq_addr;
            size_d   = dreq_size;
            strobe_d = dreq_strobe;
            wdata_d  = dreq_data;
            write_d  = |dreq_strobe;
          end else begin
            owner_d  = OWN_I;
            addr_d   = ireq_addr;
            size_d   = SW'(2);
            strobe_d = '0;
            wdata_d  = '0;
            write_d  = 1'b0;
          end
        end
      end
      BUSY: begin
        if (mresp_ready) begin
          rdata_d = mresp_rdata;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; reset abandons any in-flight transaction
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_D;
      addr_q   <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      rdata_q  <= rdata_d;
    end
  end

  // Outputs decoded only from registered state
  assign mreq_valid    = (state_q == BUSY);
  assign mreq_write    = write_q;
  assign mreq_addr     = addr_q;
  assign mreq_size     = size_q;
  assign mreq_strobe   = strobe_q;
  assign mreq_wdata    = wdata_q;
  assign iresp_data_ok = (state_q == DONE) && (owner_q == OWN_I);
  assign dresp_data_ok = (state_q == DONE) && (owner_q == OWN_D);
  // Fetch word picked by the latched address, not the live one
  assign iresp_data    = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0];
  assign dresp_data    = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with an expected-transaction scoreboard.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        mreq_valid;
  logic        mreq_write;
  logic [63:0] mreq_addr;
  logic [2:0]  mreq_size;
  logic [7:0]  mreq_strobe;
  logic [63:0] mreq_wdata;
  logic        mresp_ready;
  logic [63:0] mresp_rdata;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          is_d;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic        write;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } txn_t;

  txn_t exp_q[$];

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .mreq_valid(mreq_valid), .mreq_write(mreq_write), .mreq_addr(mreq_addr),
    .mreq_size(mreq_size), .mreq_strobe(mreq_strobe), .mreq_wdata(mreq_wdata),
    .mresp_ready(mresp_ready), .mresp_rdata(mresp_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_i(input logic [63:0] addr, input logic [63:0] rdata);
    txn_t t;
    t.is_d = 1'b0; t.addr = addr; t.size = 3'd2; t.strobe = 8'h00;
    t.write = 1'b0; t.wdata = 64'h0; t.rdata = rdata;
    exp_q.push_back(t);
  endtask

  task automatic push_d(input logic [63:0] addr, input logic [2:0] size,
                        input logic [7:0] strobe, input logic [63:0] wdata,
                        input logic [63:0] rdata);
    txn_t t;
    t.is_d = 1'b1; t.addr = addr; t.size = size; t.strobe = strobe;
    t.write = |strobe; t.wdata = wdata; t.rdata = rdata;
    exp_q.push_back(t);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Plays memory for one transaction and checks it against the scoreboard head
  task automatic serve(input int delay, input bit drop, input bit scramble);
    txn_t e;
    int n;
    logic [31:0] exp_word;
    n = 0;
    while (!mreq_valid && n < 10) begin
      step();
      n++;
    end
    if (!mreq_valid) begin
      chk("grant_timeout", 64'(mreq_valid), 64'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      chk("unexpected_grant", 64'(mreq_valid), 64'd0);
      return;
    end
    e = exp_q.pop_front();
    chk("mreq_addr", mreq_addr, e.addr);
    chk("mreq_size", 64'(mreq_size), 64'(e.size));
    chk("mreq_strobe", 64'(mreq_strobe), 64'(e.strobe));
    chk("mreq_write", 64'(mreq_write), 64'(e.write));
    if (e.write) chk("mreq_wdata", mreq_wdata, e.wdata);
    for (int i = 0; i < delay; i++) begin
      if (scramble) begin
        dreq_addr = {$urandom, $urandom};
        dreq_data = {$urandom, $urandom};
      end
      mresp_ready = 1'b0;
      mresp_rdata = {$urandom, $urandom};
      step();
      chk("stall_valid", 64'(mreq_valid), 64'd1);
      chk("stall_addr", mreq_addr, e.addr);
      chk("stall_no_ok", 64'({iresp_data_ok, dresp_data_ok}), 64'd0);
    end
    mresp_ready = 1'b1;
    mresp_rdata = e.rdata;
    step();
    mresp_ready = 1'b0;
    mresp_rdata = ~e.rdata;
    chk("iresp_ok", 64'(iresp_data_ok), 64'(!e.is_d));
    chk("dresp_ok", 64'(dresp_data_ok), 64'(e.is_d));
    chk("done_mreq_valid", 64'(mreq_valid), 64'd0);
    if (!e.is_d) begin
      exp_word = e.addr[2] ? e.rdata[63:32] : e.rdata[31:0];
      chk("iresp_data", 64'(iresp_data), 64'(exp_word));
    end else if (!e.write) begin
      chk("dresp_data", dresp_data, e.rdata);
    end
    if (drop) begin
      if (e.is_d) dreq_valid = 1'b0;
      else        ireq_valid = 1'b0;
    end
    step();
    chk("ok_one_cycle", 64'({iresp_data_ok, dresp_data_ok}), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    ireq_valid = 1'b0; ireq_addr = '0;
    dreq_valid = 1'b0; dreq_addr = '0; dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
    mresp_ready = 1'b0; mresp_rdata = '0;
    step();

    // reset: every output zero
    do_reset();
    chk("rst_mreq_valid", 64'(mreq_valid), 64'd0);
    chk("rst_ok", 64'({iresp_data_ok, dresp_data_ok}), 64'd0);
    chk("rst_iresp_data", 64'(iresp_data), 64'd0);
    chk("rst_dresp_data", dresp_data, 64'd0);
    chk("rst_mreq_addr", mreq_addr, 64'd0);
    chk("rst_mreq_misc", 64'({mreq_write, mreq_size, mreq_strobe}), 64'd0);
    chk("rst_mreq_wdata", mreq_wdata, 64'd0);

    // fetch only, upper word, one-cycle grant latency
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0004;
    push_i(64'h8000_0004, 64'h1111_2222_3333_4444);
    step();
    chk("grant_latency", 64'(mreq_valid), 64'd1);
    serve(2, 1'b1, 1'b0);

    // data write
    dreq_valid = 1'b1; dreq_addr = 64'h100; dreq_size = 3'd2;
    dreq_strobe = 8'h0F; dreq_data = 64'hDEAD_BEEF;
    push_d(64'h100, 3'd2, 8'h0F, 64'hDEAD_BEEF, 64'h0);
    serve(1, 1'b1, 1'b0);

    // data read, full 64-bit response
    dreq_valid = 1'b1; dreq_addr = 64'h208; dreq_size = 3'd3;
    dreq_strobe = 8'h00; dreq_data = 64'h0;
    push_d(64'h208, 3'd3, 8'h00, 64'h0, 64'hA5A5_0123_4567_89AB);
    serve(0, 1'b1, 1'b0);

    // fetch, lower word
    ireq_valid = 1'b1; ireq_addr = 64'h1000;
    push_i(64'h1000, 64'hCAFE_F00D_1234_5678);
    serve(3, 1'b1, 1'b0);

    // simultaneous requesters held high from reset
    do_reset();
    ireq_valid = 1'b1; ireq_addr = 64'h2000;
    dreq_valid = 1'b1; dreq_addr = 64'h3000; dreq_size = 3'd3;
    dreq_strobe = 8'h00; dreq_data = 64'h0;
`ifdef ARB_RR_EN
    push_i(64'h2000, 64'h0000_0001_0000_0002);
    push_d(64'h3000, 3'd3, 8'h00, 64'h0, 64'h0000_0003_0000_0004);
    push_i(64'h2000, 64'h0000_0005_0000_0006);
`else
    push_d(64'h3000, 3'd3, 8'h00, 64'h0, 64'h0000_0003_0000_0004);
    push_d(64'h3000, 3'd3, 8'h00, 64'h0, 64'h0000_0007_0000_0008);
    push_d(64'h3000, 3'd3, 8'h00, 64'h0, 64'h0000_0009_0000_000A);
`endif
    serve(1, 1'b0, 1'b0);
    serve(1, 1'b0, 1'b0);
    serve(1, 1'b0, 1'b0);
    ireq_valid = 1'b0;
    dreq_valid = 1'b0;
    step();
    chk("tie_drained", 64'(mreq_valid), 64'd0);

    // request fields stay latched while requester inputs change
    dreq_valid = 1'b1; dreq_addr = 64'h400; dreq_size = 3'd3;
    dreq_strobe = 8'h00; dreq_data = 64'h0;
    push_d(64'h400, 3'd3, 8'h00, 64'h0, 64'h1357_9BDF_2468_ACE0);
    serve(4, 1'b1, 1'b1);

    // long memory stall
    dreq_valid = 1'b1; dreq_addr = 64'h4F0; dreq_size = 3'd1;
    dreq_strobe = 8'h30; dreq_data = 64'h0000_BEEF_0000_0000;
    push_d(64'h4F0, 3'd1, 8'h30, 64'h0000_BEEF_0000_0000, 64'h0);
    serve(20, 1'b1, 1'b0);

    // reset mid-transaction; the late completion must be ignored
    dreq_valid = 1'b1; dreq_addr = 64'h500; dreq_size = 3'd3;
    dreq_strobe = 8'h00; dreq_data = 64'h0;
    step();
    chk("midrst_busy", 64'(mreq_valid), 64'd1);
    rst = 1'b0;
    dreq_valid = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_valid", 64'(mreq_valid), 64'd0);
    chk("midrst_addr", mreq_addr, 64'd0);
    mresp_ready = 1'b1;
    mresp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    mresp_ready = 1'b0;
    chk("late_ready_valid", 64'(mreq_valid), 64'd0);
    chk("late_ready_ok", 64'({iresp_data_ok, dresp_data_ok}), 64'd0);
    step();
    chk("late_ready_ok2", 64'({iresp_data_ok, dresp_data_ok}), 64'd0);
    chk("late_ready_data", dresp_data, 64'd0);

    // normal service after the abandoned transaction
    ireq_valid = 1'b1; ireq_addr = 64'h600;
    push_i(64'h600, 64'h7777_8888_9999_AAAA);
    serve(1, 1'b1, 1'b0);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
